// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: FSM state encoding, default
// data width and the sizing rule for the ISSUE+WAIT cycle counter.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } gcd_state_e;

    // Bits needed to hold every counter value 0..timeout inclusive.
    function automatic int cnt_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end else begin
            return $clog2(timeout + 1);
        end
    endfunction

endpackage

// File: rtl/gcd_requester.sv
// Initiator side of the GCD operand/result interface. Takes one operand pair
// at a time from the command port, hands it to the external GCD engine, and
// returns the engine result (or a timeout marker) on the response port.
// b==0 is answered locally because the engine never terminates on it.
// Every output is a flop loaded from the next-state decode, so no input
// reaches an output combinationally.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic               cmd_ready,
    output logic               gcd_in_valid,
    output logic [2*WIDTH-1:0] gcd_in_data,
    input  logic               gcd_in_ready,
    input  logic               gcd_out_valid,
    input  logic [WIDTH-1:0]   gcd_out_data,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_timeout,
    input  logic               rsp_ready,
    output logic               busy,
    output logic               err
);

    localparam int              CW        = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]   TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};

    gcd_state_e        state_r,       state_s;
    logic [CW-1:0]     cnt_r,         cnt_s;
    logic [WIDTH-1:0]  a_r,           a_s;
    logic [WIDTH-1:0]  b_r,           b_s;
    logic [WIDTH-1:0]  rsp_data_r,    rsp_data_s;
    logic              rsp_timeout_r, rsp_timeout_s;
    logic              err_r,         err_s;
    logic              cmd_ready_r;
    logic              gcd_in_valid_r;
    logic              rsp_valid_r;
    logic              busy_r;
    logic [CW-1:0]     cnt_inc_s;
    logic              cnt_hit_s;

    // Saturating increment of the wait counter and terminal-count detect.
    always_comb begin
        cnt_hit_s = (cnt_r == TIMEOUT_C);
        if (cnt_hit_s) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Next-state, operand and response decode.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        a_s           = a_r;
        b_s           = b_r;
        rsp_data_s    = rsp_data_r;
        rsp_timeout_s = rsp_timeout_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    a_s   = cmd_a;
                    b_s   = cmd_b;
                    cnt_s = CNT_ZERO;
                    if (cmd_b == {WIDTH{1'b0}}) begin
                        // gcd(a,0)=a, including gcd(0,0)=0; the engine would hang.
                        state_s       = RESP;
                        rsp_data_s    = cmd_a;
                        rsp_timeout_s = 1'b0;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_s = cnt_inc_s;
                if (cnt_hit_s) begin
                    // Terminal count wins over a late handshake so the
                    // ISSUE+WAIT budget stays bounded by TIMEOUT+1 cycles.
                    state_s       = RESP;
                    rsp_data_s    = {WIDTH{1'b0}};
                    rsp_timeout_s = 1'b1;
                end else if (gcd_in_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                cnt_s = cnt_inc_s;
                if (gcd_out_valid) begin
                    // A result on the terminal-count cycle still counts.
                    state_s       = RESP;
                    rsp_data_s    = gcd_out_data;
                    rsp_timeout_s = 1'b0;
                end else if (cnt_hit_s) begin
                    state_s       = RESP;
                    rsp_data_s    = {WIDTH{1'b0}};
                    rsp_timeout_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (rsp_timeout_r) begin
                        state_s = ERR;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = RESP;
                end
            end
            ERR: begin
                state_s = ERR;
            end
            default: begin
                state_s = ERR;
            end
        endcase
    end

    // Sticky error: entering ERR, or an engine pulse outside WAIT.
    always_comb begin
        if ((state_s == ERR) || (gcd_out_valid && (state_r != WAIT))) begin
            err_s = 1'b1;
        end else begin
            err_s = err_r;
        end
    end

    // State, counter and data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            rsp_data_r    <= {WIDTH{1'b0}};
            rsp_timeout_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            a_r           <= a_s;
            b_r           <= b_s;
            rsp_data_r    <= rsp_data_s;
            rsp_timeout_r <= rsp_timeout_s;
            err_r         <= err_s;
        end
    end

    // Handshake and status outputs, registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_ready_r    <= 1'b1;
            gcd_in_valid_r <= 1'b0;
            rsp_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            cmd_ready_r    <= (state_s == IDLE);
            gcd_in_valid_r <= (state_s == ISSUE);
            rsp_valid_r    <= (state_s == RESP);
            busy_r         <= (state_s != IDLE);
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign gcd_in_valid = gcd_in_valid_r;
    assign gcd_in_data  = {a_r, b_r};
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_timeout  = rsp_timeout_r;
    assign busy         = busy_r;
    assign err          = err_r;

endmodule
